// File: rtl/karatsuba_seq_mult.sv
// Multi-cycle Karatsuba multiplier: three half-width sub-products on one shared
// (H+1)x(H+1) multiplier. Optional signed mode via the KARATSUBA_SIGNED_EN macro.
`timescale 1ns/1ps
module karatsuba_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int ZW = 2 * H + 2;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_widthCheck
      $error("karatsuba_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE, DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2*H-1:0]  r_z0;
  logic [2*H-1:0]  r_z2;
  logic [ZW-1:0]   r_zm;
  logic [PW-1:0]   r_p;
  logic            r_outValid;
`ifdef KARATSUBA_SIGNED_EN
  logic            r_neg;
`endif

  logic [H:0]      w_sumA;
  logic [H:0]      w_sumB;
  logic [H:0]      w_mulA;
  logic [H:0]      w_mulB;
  logic [ZW-1:0]   w_prod;
  logic [ZW-1:0]   w_z1;
  logic [PW-1:0]   w_comb;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = MUL_LO;
      MUL_LO:  w_nextState = MUL_HI;
      MUL_HI:  w_nextState = MUL_MID;
      MUL_MID: w_nextState = COMBINE;
      COMBINE: w_nextState = DONE;
      DONE:    if (r_outValid && out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_sumA = {1'b0, r_a[WIDTH-1:H]} + {1'b0, r_a[H-1:0]};
  assign w_sumB = {1'b0, r_b[WIDTH-1:H]} + {1'b0, r_b[H-1:0]};

  // Operand select for the single shared multiplier.
  always_comb begin
    w_mulA = '0;
    w_mulB = '0;
    case (r_state)
      MUL_LO: begin
        w_mulA = {1'b0, r_a[H-1:0]};
        w_mulB = {1'b0, r_b[H-1:0]};
      end
      MUL_HI: begin
        w_mulA = {1'b0, r_a[WIDTH-1:H]};
        w_mulB = {1'b0, r_b[WIDTH-1:H]};
      end
      MUL_MID: begin
        w_mulA = w_sumA;
        w_mulB = w_sumB;
      end
      default: ;
    endcase
  end

  assign w_prod = ZW'(w_mulA) * ZW'(w_mulB);
  assign w_z1   = r_zm - ZW'(r_z2) - ZW'(r_z0);
  assign w_comb = (PW'(r_z2) << WIDTH) + (PW'(w_z1) << H) + PW'(r_z0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_z0       <= '0;
      r_z2       <= '0;
      r_zm       <= '0;
      r_p        <= '0;
      r_outValid <= 1'b0;
`ifdef KARATSUBA_SIGNED_EN
      r_neg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
`ifdef KARATSUBA_SIGNED_EN
            // Magnitudes fit unsigned; even the most negative value maps to 2^(WIDTH-1).
            r_a   <= a[WIDTH-1] ? -a : a;
            r_b   <= b[WIDTH-1] ? -b : b;
            r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
`else
            r_a   <= a;
            r_b   <= b;
`endif
          end
        end
        MUL_LO:  r_z0 <= w_prod[2*H-1:0];
        MUL_HI:  r_z2 <= w_prod[2*H-1:0];
        MUL_MID: r_zm <= w_prod;
        COMBINE: begin
`ifdef KARATSUBA_SIGNED_EN
          r_p <= r_neg ? -w_comb : w_comb;
`else
          r_p <= w_comb;
`endif
          r_outValid <= 1'b1;
        end
        DONE:    if (out_ready) r_outValid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign p         = r_p;

endmodule
